// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: load-size encodings, widths and the MEM/WB record.
package mips_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // Contents of the MEM/WB pipeline register
    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic [REG_ADDR_W-1:0] write_reg;
        logic [DATA_W-1:0]     alu_result;
        logic [DATA_W-1:0]     read_data;
        logic [1:0]            load_size;
        logic                  load_signed;
    } mem_wb_t;

endpackage

// File: rtl/load_extract.sv
// Load data lane select, zero/sign extension and misalignment detection.
// WB_SUBWORD_LOAD_EN: when defined, byte/half loads are extracted and extended;
// otherwise every load passes the full word and any nonzero offset is misaligned.
module load_extract
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        offset,
    input  logic [1:0]        load_size,
    input  logic              load_signed,
    input  logic              is_load,
    output logic [DATA_W-1:0] data,
    output logic              misaligned
);

`ifdef WB_SUBWORD_LOAD_EN
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed byte and half-word lanes
    always_comb begin
        byte_lane = word[7:0];
        case (offset)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        half_lane = offset[1] ? word[31:16] : word[15:0];
    end

    // Extend per size; the reserved size encoding behaves as a word
    always_comb begin
        data       = word;
        misaligned = 1'b0;
        case (load_size)
            LS_BYTE: begin
                data       = {{24{load_signed & byte_lane[7]}}, byte_lane};
                misaligned = 1'b0;
            end
            LS_HALF: begin
                data       = {{16{load_signed & half_lane[15]}}, half_lane};
                misaligned = offset[0];
            end
            default: begin
                data       = word;
                misaligned = (offset != 2'b00);
            end
        endcase
        misaligned = misaligned & is_load;
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{load_size, load_signed};

    // Word-only loads: any nonzero offset is an error
    always_comb begin
        data       = word;
        misaligned = is_load & (offset != 2'b00);
    end
`endif

endmodule

// File: rtl/wb_stage.sv
// MIPS writeback stage: MEM/WB register, result mux, register file write port,
// forwarding tap, sticky misalignment flag and retired-instruction counter.
// Sub-word load support is enabled by defining WB_SUBWORD_LOAD_EN.
module wb_stage
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  memValid,
    input  logic                  memRegWrite,
    input  logic                  memToReg,
    input  logic [REG_ADDR_W-1:0] memWriteReg,
    input  logic [DATA_W-1:0]     memAluResult,
    input  logic [DATA_W-1:0]     memReadData,
    input  logic [1:0]            memLoadSize,
    input  logic                  memLoadSigned,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  regWrite,
    output logic [REG_ADDR_W-1:0] writeRegister,
    output logic [DATA_W-1:0]     writeData,
    output logic                  fwdValid,
    output logic                  alignErr,
    output logic [CNT_W-1:0]      retireCount
);

    mem_wb_t           wb_q, wb_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;
    logic [DATA_W-1:0] load_data;
    logic              misaligned;
    logic              retire;

    // Next MEM/WB contents: capture unless stalled; flush always kills valid
    always_comb begin
        wb_d = wb_q;
        if (!stall) begin
            wb_d.reg_write   = memRegWrite;
            wb_d.mem_to_reg  = memToReg;
            wb_d.write_reg   = memWriteReg;
            wb_d.alu_result  = memAluResult;
            wb_d.read_data   = memReadData;
            wb_d.load_size   = memLoadSize;
            wb_d.load_signed = memLoadSigned;
            wb_d.valid       = memValid & ~flush;
        end else if (flush) begin
            wb_d.valid = 1'b0;
        end
    end

    assign retire = ~stall & memValid & ~flush;

    // Pipeline register, retire counter and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            wb_q <= wb_d;
            if (retire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            err_q <= err_q | (wb_q.valid & misaligned);
        end
    end

    load_extract u_load_extract (
        .word        (wb_q.read_data),
        .offset      (wb_q.alu_result[1:0]),
        .load_size   (wb_q.load_size),
        .load_signed (wb_q.load_signed),
        .is_load     (wb_q.mem_to_reg),
        .data        (load_data),
        .misaligned  (misaligned)
    );

    // Register file write port; the error flag reports in the same cycle as the bad load
    always_comb begin
        writeData     = wb_q.mem_to_reg ? load_data : wb_q.alu_result;
        writeRegister = wb_q.write_reg;
        regWrite      = wb_q.valid & wb_q.reg_write & (wb_q.write_reg != REG_ZERO) & ~misaligned;
        fwdValid      = regWrite;
        alignErr      = err_q | (wb_q.valid & misaligned);
        retireCount   = cnt_q;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

MIPS writeback stage: registers the memory-stage result into the MEM/WB pipeline register, selects ALU or load data, aligns and extends sub-word loads, and drives the register file write port (`regWrite`, `writeRegister`, `writeData`). It sits directly upstream of the register file. It also provides a forwarding tap for the execute stage and a retired-instruction counter.

## Interface
- `CNT_W`, 32, retired-instruction counter width
- `clk` input 1: single clock; all state updates on rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `memValid` input 1: MEM stage holds a real instruction
- `memRegWrite` input 1: instruction writes a register
- `memToReg` input 1: 1 = load data, 0 = ALU result
- `memWriteReg` input 5: destination register number
- `memAluResult` input 32: ALU result; bits [1:0] are the load byte offset
- `memReadData` input 32: raw word read from data memory
- `memLoadSize` input 2: 00 byte, 01 half, 10 word, 11 reserved (treated as word)
- `memLoadSigned` input 1: sign-extend sub-word loads
- `stall` input 1: hold the MEM/WB register
- `flush` input 1: kill the instruction being captured
- `regWrite` output 1: register file write enable
- `writeRegister` output 5: register file write address
- `writeData` output 32: register file write data
- `fwdValid` output 1: forwarding tap valid; equals `regWrite`
- `alignErr` output 1: sticky misaligned-load flag
- `retireCount` output CNT_W: count of retired valid instructions

## Operation
- Capture condition: `!stall`. On capture, the register loads all `mem*` fields. Captured valid = `memValid & !flush`.
- `flush` has priority over `stall`. With `flush=1`, valid clears even while `stall=1`. Other fields hold.
- With `stall=1` and `flush=0`, all register contents hold.
- Result mux (combinational from register contents):
  - `memToReg=0`: ALU result.
  - `memToReg=1`: load data processed by the extractor.
- Extractor:
  - Byte: select lane `offset*8`, then zero- or sign-extend per `memLoadSigned`.
  - Half: `offset[1]` selects bits [31:16] or [15:0], then extend.
  - Word: pass through.
- Misalignment: a registered load is misaligned if it is a half with `offset[0]=1`, or a word with `offset!=0`.
- `regWrite` = valid & regWrite field & (`writeRegister!=0`) & !misaligned. Writes to $zero are never issued.
- `alignErr` sets on any valid registered misaligned load. It is cleared only by reset.
- `retireCount` increments by 1 on each capture with captured valid=1. It wraps from 2^CNT_W−1 to 0.

## Timing
- Latency: `mem*` inputs to `regWrite`/`writeData` is 1 cycle. Outputs are valid for the whole cycle after capture. The register file writes at the following edge.
- Reset values:
  - `regWrite=0`, `writeRegister=0`, `writeData=0`, `fwdValid=0`.
  - `alignErr=0`, `retireCount=0`.
  - All register fields are 0.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge. The in-flight instruction is lost.
- During a held stall, outputs stay constant. Downstream writes are idempotent, so repeating the same write is harmless.
- `flush` and `stall` together on one edge: a bubble is inserted and the counter does not increment.

## Configuration
- `WB_SUBWORD_LOAD_EN` defined: full byte/half extraction and misalignment checks as described above.
- `WB_SUBWORD_LOAD_EN` undefined:
  - `memLoadSize` and `memLoadSigned` are ignored.
  - Loads always pass the full word.
  - Misalignment is checked only as `offset!=0` on loads.

## Structure
- Shared package `mips_pkg` holds:
  - Load-size encodings: `LS_BYTE=2'b00`, `LS_HALF=2'b01`, `LS_WORD=2'b10`.
  - `REG_ZERO=5'd0`.
  - `DATA_W=32`, `REG_ADDR_W=5`.
- One sub-module: `load_extract` (combinational lane select, extension, and misalign detect). It is instantiated once.
- The pipeline register, counter, and sticky flag live in `wb_stage`.

## Test plan
- Reset, then a valid ALU write to reg 8 with data 0x1234_5678 → next cycle `regWrite=1`, `writeRegister=8`, `writeData=0x12345678`, `retireCount=1`.
- Signed byte load, word 0x80FF_7F01, offset 2 → `writeData=0xFFFFFFFF`. Unsigned, same word, offset 3 → `0x00000080`.
- Half load at offset 1 → `regWrite=0`, `alignErr=1`. `alignErr` stays 1 through 10 further valid writes until `rst_n` pulses low.
- Write to reg 0 with data 0xDEAD_BEEF → `regWrite=0`, `fwdValid=0`, `retireCount` still increments.
- `stall=1` for 3 cycles with new inputs → outputs unchanged. `stall=1` with `flush=1` → `regWrite=0` next cycle, counter unchanged.
- Preload the counter by running 2^CNT_W−1 retires (CNT_W=4 in bench), then one more → `retireCount=0`. Assert `rst_n` mid-cycle → all outputs 0 asynchronously.
